// File: rtl/mix_columns_serial.sv
// AES MixColumns / InvMixColumns, iterative over the four state columns.
// A 128-bit state is captured on an accepted enable and transformed in place,
// COLS_PER_CYCLE columns per clock. The result lands in the mixed register
// together with a one-cycle done_flag. last_round passes the state straight
// through in one cycle. State byte i sits at in[8i+:8]; the ports use an
// ascending [0:127] range so a FIPS-197 hex string reads left to right.

module mix_col_unit #(
    parameter bit INVERSE = 1'b0
) (
    input  logic [0:31] col_in,
    output logic [0:31] col_out
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by one of the small constants the two matrices use.
    function automatic logic [7:0] gmul(input logic [7:0] b, input int k);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (k)
            2:       return x2;
            3:       return x2 ^ b;
            9:       return x8 ^ b;
            11:      return x8 ^ x2 ^ b;
            13:      return x8 ^ x4 ^ b;
            14:      return x8 ^ x4 ^ x2;
            default: return b;
        endcase
    endfunction

    // First matrix row; each later output row is this row rotated right.
    function automatic int coef(input int idx);
        case (idx)
            0:       return INVERSE ? 14 : 2;
            1:       return INVERSE ? 11 : 3;
            2:       return INVERSE ? 13 : 1;
            default: return INVERSE ? 9 : 1;
        endcase
    endfunction

    // Output byte i = XOR over j of coef[(j - i) mod 4] * s_j.
    always_comb begin
        col_out = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                col_out[8*i +: 8] = col_out[8*i +: 8] ^ gmul(col_in[8*j +: 8], coef((j - i + 4) % 4));
            end
        end
    end

endmodule

module mix_columns_serial #(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit INVERSE        = 1'b0
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [0:127] in,
    input  logic         enable,
    input  logic         last_round,
    output logic [0:127] mixed,
    output logic         done_flag,
    output logic         busy
);

    localparam int PASSES = 4 / COLS_PER_CYCLE;
    localparam int CW     = (PASSES > 1) ? $clog2(PASSES) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [0:127]   work_q, work_d;
    logic [0:127]   mixed_q, mixed_d;
    logic           done_q, done_d;

    logic [COLS_PER_CYCLE-1:0][0:31] col_in, col_out;

    // Route the columns selected by the pass counter into the multipliers.
    always_comb begin
        col_in = '0;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            col_in[g] = work_q[32*(int'(cnt_q)*COLS_PER_CYCLE + g) +: 32];
        end
    end

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        mix_col_unit #(.INVERSE(INVERSE)) u_col (
            .col_in (col_in[g]),
            .col_out(col_out[g])
        );
    end

    // State register; reset aborts any transform in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            mixed_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            mixed_q <= mixed_d;
            done_q  <= done_d;
        end
    end

    // Next state: accept in IDLE, write transformed columns back in RUN,
    // publish the full state only on the final pass.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        mixed_d = mixed_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    if (last_round) begin
                        mixed_d = in;
                        done_d  = 1'b1;
                    end else begin
                        work_d  = in;
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                    work_d[32*(int'(cnt_q)*COLS_PER_CYCLE + g) +: 32] = col_out[g];
                end
                if (cnt_q == CW'(PASSES - 1)) begin
                    mixed_d = work_d;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs come straight from registers.
    always_comb begin
        mixed     = mixed_q;
        done_flag = done_q;
        busy      = (state_q == RUN);
    end

endmodule

// File: tb/tb_mix_columns_serial.sv
// Directed bench: four instances share the stimulus -- forward N=1, N=2, N=4
// and inverse N=1 -- and each scenario task checks the instances it targets.
module tb_mix_columns_serial;

    localparam logic [0:127] A  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [0:127] F  = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [0:127] X  = 128'hdb135345f20a225c01010101c6c6c6c6;
    localparam logic [0:127] XR = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
    localparam logic [0:127] Y  = 128'hd4d4d4d5000000000000000000000000;
    localparam logic [0:127] YR = 128'hd5d5d7d6000000000000000000000000;
    localparam logic [0:127] P  = 128'h00112233445566778899aabbccddeeff;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         en = 1'b0, lr = 1'b0;
    logic [0:127] din = '0;
    logic [0:127] mx0, mx1, mx2, mx3;
    logic         dn0, dn1, dn2, dn3, bs0, bs1, bs2, bs3;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Per-instance observations from the last observe() window.
    int           done_at[4], done2_at[4], ndone[4], busy_n[4];
    logic         consec[4];
    logic [0:127] res[4], res2[4];
    int           lat[4] = '{4, 2, 1, 4};

    always #5 CLK = ~CLK;

    mix_columns_serial #(.COLS_PER_CYCLE(1), .INVERSE(1'b0)) u_n1 (
        .CLK(CLK), .RST(RST), .in(din), .enable(en), .last_round(lr),
        .mixed(mx0), .done_flag(dn0), .busy(bs0));
    mix_columns_serial #(.COLS_PER_CYCLE(2), .INVERSE(1'b0)) u_n2 (
        .CLK(CLK), .RST(RST), .in(din), .enable(en), .last_round(lr),
        .mixed(mx1), .done_flag(dn1), .busy(bs1));
    mix_columns_serial #(.COLS_PER_CYCLE(4), .INVERSE(1'b0)) u_n4 (
        .CLK(CLK), .RST(RST), .in(din), .enable(en), .last_round(lr),
        .mixed(mx2), .done_flag(dn2), .busy(bs2));
    mix_columns_serial #(.COLS_PER_CYCLE(1), .INVERSE(1'b1)) u_inv (
        .CLK(CLK), .RST(RST), .in(din), .enable(en), .last_round(lr),
        .mixed(mx3), .done_flag(dn3), .busy(bs3));

    // Drive one request so that it is accepted at the next rising edge.
    task automatic issue(input logic [0:127] data, input logic last);
        @(negedge CLK);
        din = data;
        lr  = last;
        en  = 1'b1;
        @(posedge CLK);
    endtask

    // Sample every falling edge for len cycles; m counts edges after accept.
    // With hold=1 enable stays high and din switches to nxt at m=0.
    task automatic observe(input int len, input logic hold, input logic [0:127] nxt);
        logic         dv[4], bv[4], prev[4];
        logic [0:127] mv[4];
        for (int d = 0; d < 4; d++) begin
            done_at[d] = -1; done2_at[d] = -1; ndone[d] = 0; busy_n[d] = 0;
            consec[d] = 1'b0; prev[d] = 1'b0; res[d] = '0; res2[d] = '0;
        end
        for (int m = 0; m < len; m++) begin
            @(negedge CLK);
            dv = '{dn0, dn1, dn2, dn3};
            bv = '{bs0, bs1, bs2, bs3};
            mv = '{mx0, mx1, mx2, mx3};
            for (int d = 0; d < 4; d++) begin
                if (dv[d] === 1'b1) begin
                    ndone[d]++;
                    if (prev[d]) consec[d] = 1'b1;
                    if (done_at[d] < 0) begin done_at[d] = m; res[d] = mv[d]; end
                    else if (done2_at[d] < 0) begin done2_at[d] = m; res2[d] = mv[d]; end
                end
                if (bv[d] === 1'b1) busy_n[d]++;
                prev[d] = (dv[d] === 1'b1);
            end
            if (m == 0) begin
                if (hold) din = nxt;
                else en = 1'b0;
            end
        end
        en = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        #12;
        vec_cnt++; if (mx0 !== '0) begin err_cnt++; $display("FAIL reset_mixed n1 got %h exp 0", mx0); end
        vec_cnt++; if (mx2 !== '0) begin err_cnt++; $display("FAIL reset_mixed n4 got %h exp 0", mx2); end
        vec_cnt++; if (dn0 !== 1'b0) begin err_cnt++; $display("FAIL reset_done got %b exp 0", dn0); end
        vec_cnt++; if (bs0 !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got %b exp 0", bs0); end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_fips_round;
        issue(A, 1'b0);
        observe(8, 1'b0, '0);
        for (int d = 0; d < 3; d++) begin
            vec_cnt++; if (res[d] !== F) begin err_cnt++; $display("FAIL fips_res[%0d] got %h exp %h", d, res[d], F); end
            vec_cnt++; if (done_at[d] !== lat[d]) begin err_cnt++; $display("FAIL fips_lat[%0d] got %0d exp %0d", d, done_at[d], lat[d]); end
            vec_cnt++; if (ndone[d] !== 1) begin err_cnt++; $display("FAIL fips_ndone[%0d] got %0d exp 1", d, ndone[d]); end
            vec_cnt++; if (busy_n[d] !== lat[d]) begin err_cnt++; $display("FAIL fips_busy[%0d] got %0d exp %0d", d, busy_n[d], lat[d]); end
        end
        vec_cnt++; if (mx0 !== F) begin err_cnt++; $display("FAIL fips_hold got %h exp %h", mx0, F); end
    endtask

    task automatic test_columns;
        logic [0:127] vin[2]  = '{X, Y};
        logic [0:127] vexp[2] = '{XR, YR};
        for (int v = 0; v < 2; v++) begin
            issue(vin[v], 1'b0);
            observe(8, 1'b0, '0);
            for (int d = 0; d < 3; d++) begin
                vec_cnt++; if (res[d] !== vexp[v]) begin err_cnt++; $display("FAIL col%0d_res[%0d] got %h exp %h", v, d, res[d], vexp[v]); end
                vec_cnt++; if (done_at[d] !== lat[d]) begin err_cnt++; $display("FAIL col%0d_lat[%0d] got %0d exp %0d", v, d, done_at[d], lat[d]); end
            end
        end
    endtask

    task automatic test_inverse;
        logic [0:127] vin[2]  = '{F, XR};
        logic [0:127] vexp[2] = '{A, X};
        for (int v = 0; v < 2; v++) begin
            issue(vin[v], 1'b0);
            observe(8, 1'b0, '0);
            vec_cnt++; if (res[3] !== vexp[v]) begin err_cnt++; $display("FAIL inv%0d_res got %h exp %h", v, res[3], vexp[v]); end
            vec_cnt++; if (done_at[3] !== 4) begin err_cnt++; $display("FAIL inv%0d_lat got %0d exp 4", v, done_at[3]); end
        end
    endtask

    task automatic test_bypass;
        issue(P, 1'b1);
        observe(6, 1'b0, '0);
        lr = 1'b0;
        for (int d = 0; d < 4; d++) begin
            vec_cnt++; if (res[d] !== P) begin err_cnt++; $display("FAIL byp_res[%0d] got %h exp %h", d, res[d], P); end
            vec_cnt++; if (done_at[d] !== 0) begin err_cnt++; $display("FAIL byp_lat[%0d] got %0d exp 0", d, done_at[d]); end
            vec_cnt++; if (ndone[d] !== 1 || busy_n[d] !== 0) begin err_cnt++; $display("FAIL byp_pulse[%0d] got done=%0d busy=%0d exp 1/0", d, ndone[d], busy_n[d]); end
        end
    endtask

    task automatic test_back_to_back;
        int exp_d2[3] = '{9, 5, 3};
        issue(A, 1'b0);
        observe(12, 1'b1, X);
        repeat (8) @(negedge CLK);
        for (int d = 0; d < 3; d++) begin
            vec_cnt++; if (res[d] !== F) begin err_cnt++; $display("FAIL b2b_first[%0d] got %h exp %h", d, res[d], F); end
            vec_cnt++; if (res2[d] !== XR) begin err_cnt++; $display("FAIL b2b_second[%0d] got %h exp %h", d, res2[d], XR); end
            vec_cnt++; if (done_at[d] !== lat[d] || done2_at[d] !== exp_d2[d]) begin err_cnt++; $display("FAIL b2b_lat[%0d] got %0d/%0d exp %0d/%0d", d, done_at[d], done2_at[d], lat[d], exp_d2[d]); end
            vec_cnt++; if (consec[d] !== 1'b0) begin err_cnt++; $display("FAIL b2b_consec[%0d] got %b exp 0", d, consec[d]); end
        end
    endtask

    task automatic test_mid_reset;
        issue(A, 1'b0);
        @(negedge CLK);
        en = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        #1;
        vec_cnt++; if (mx0 !== '0) begin err_cnt++; $display("FAIL midrst_mixed got %h exp 0", mx0); end
        vec_cnt++; if (bs0 !== 1'b0) begin err_cnt++; $display("FAIL midrst_busy got %b exp 0", bs0); end
        vec_cnt++; if (dn0 !== 1'b0) begin err_cnt++; $display("FAIL midrst_done got %b exp 0", dn0); end
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        observe(8, 1'b0, '0);
        vec_cnt++; if (ndone[0] !== 0 || busy_n[0] !== 0) begin err_cnt++; $display("FAIL midrst_ghost got done=%0d busy=%0d exp 0/0", ndone[0], busy_n[0]); end
        issue(X, 1'b0);
        observe(8, 1'b0, '0);
        vec_cnt++; if (res[0] !== XR || done_at[0] !== 4) begin err_cnt++; $display("FAIL midrst_after got %h@%0d exp %h@4", res[0], done_at[0], XR); end
    endtask

    initial begin
        #1;
        test_reset();
        test_fips_round();
        test_columns();
        test_inverse();
        test_bypass();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
